// File: rtl/dds_wave_gen.sv
// DDS sample source: phase accumulator -> saw/tri/square/DC -> gain, offset, clamp -> valid/ready sample register.
// Tick-to-valid latency 2 clk; a new sample that finds the previous one still unaccepted is dropped and counted.
module dds_wave_gen #(
  parameter int PHASE_W    = 32,
  parameter int SAMPLE_DIV = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [11:0]        duty,
  input  logic [11:0]        amp,
  input  logic [11:0]        offset,
  output logic [11:0]        dac_code,
  output logic               dac_valid,
  input  logic               dac_ready,
  output logic               sync,
  output logic [15:0]        overrun_cnt
);

  localparam int              CNT_W    = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0]   cnt_q;
  logic [PHASE_W-1:0] phase_q;
  logic               sync_q;
  logic               s1_vld_q;
  logic [11:0]        raw_q;
  logic [11:0]        amp_q;
  logic [11:0]        off_q;
  logic [11:0]        code_q;
  logic               valid_q;
  logic [15:0]        ovr_q;

  logic               tick;
  logic [PHASE_W:0]   phase_sum;
  logic [11:0]        p;
  logic [11:0]        raw_d;

  assign tick      = enable && (cnt_q == CNT_LAST);
  assign phase_sum = {1'b0, phase_q} + {1'b0, freq_word};
  assign p         = phase_q[PHASE_W-1 -: 12];

  // Waveform shaping uses the config sampled at the tick, so wave_sel/duty need no separate shadow.
  always_comb begin
    raw_d = 12'h800;
    case (wave_sel)
      2'd0:    raw_d = p;
      2'd1:    raw_d = p[11] ? ~{p[10:0], 1'b0} : {p[10:0], 1'b0};
      2'd2:    raw_d = (p < duty) ? 12'hFFF : 12'h000;
      default: raw_d = 12'h800;
    endcase
  end

  logic signed [12:0] s;
  logic signed [13:0] gain;
  logic signed [26:0] s_x;
  logic signed [26:0] g_x;
  logic signed [26:0] prod;
  logic signed [14:0] sc;
  logic signed [14:0] v;
  logic [11:0]        samp_d;

  assign s    = $signed({1'b0, raw_q}) - 13'sd2048;
  assign gain = $signed({2'b00, amp_q}) + 14'sd1;
  assign s_x  = {{14{s[12]}}, s};
  assign g_x  = {{13{gain[13]}}, gain};
  assign prod = s_x * g_x;
  // Taking bits [26:12] of the signed product is the arithmetic shift right by 12.
  assign sc   = prod[26:12];
  assign v    = $signed({3'b000, off_q}) + sc;

  always_comb begin
    samp_d = v[11:0];
    if (v[14]) begin
      samp_d = 12'h000;
    end else if (v[13:12] != 2'b00) begin
      samp_d = 12'hFFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      phase_q  <= '0;
      sync_q   <= 1'b0;
      s1_vld_q <= 1'b0;
      raw_q    <= 12'h000;
      amp_q    <= 12'h000;
      off_q    <= 12'h000;
      code_q   <= 12'h000;
      valid_q  <= 1'b0;
      ovr_q    <= 16'h0000;
    end else begin
      sync_q   <= 1'b0;
      s1_vld_q <= 1'b0;
      if (!enable) begin
        cnt_q   <= '0;
        phase_q <= '0;
      end else begin
        cnt_q <= tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          phase_q  <= phase_sum[PHASE_W-1:0];
          sync_q   <= phase_sum[PHASE_W];
          s1_vld_q <= 1'b1;
          raw_q    <= raw_d;
          amp_q    <= amp;
          off_q    <= offset;
        end
      end

      if (s1_vld_q && (!valid_q || dac_ready)) begin
        code_q  <= samp_d;
        valid_q <= 1'b1;
      end else if (s1_vld_q) begin
        if (ovr_q != 16'hFFFF) begin
          ovr_q <= ovr_q + 1'b1;
        end
      end else if (valid_q && dac_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign dac_code    = code_q;
  assign dac_valid   = valid_q;
  assign sync        = sync_q;
  assign overrun_cnt = ovr_q;

endmodule
